// File: rtl/debug_snapshot_ctrl.sv
// Debug snapshot sequencer: copies one of two 16-byte probe pages byte-serially
// into a shadow bank that stays stable while the hex overlay row is drawn.
module debug_snapshot_ctrl #(
    parameter logic [10:0] CAPLINE = 11'd256,
    parameter logic [7:0]  DECIM   = 8'd1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clken,
    input  logic [10:0]  hc,
    input  logic [10:0]  vc,
    input  logic [1:0]   mode,
    input  logic         page,
    input  logic         trig,
    input  logic [127:0] probe_p0,
    input  logic [127:0] probe_p1,
    output logic [127:0] shadow,
    output logic         busy,
    output logic         armed,
    output logic         cap_done,
    output logic [7:0]   cap_seq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_COPY,
        S_HOLD
    } state_e;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_SHOT = 2'b10;
    // A DECIM of 0 behaves like 1: capture every frame.
    localparam logic [7:0] RELOAD    = (DECIM == 8'd0) ? 8'd0 : DECIM - 8'd1;

    state_e       state_q, state_d;
    logic [7:0]   dec_q, dec_d;
    logic         trig_q, trig_d;
    logic         page_q, page_d;
    logic [3:0]   idx_q, idx_d;
    logic         shot_q, shot_d;
    logic [127:0] shadow_q, shadow_d;
    logic [7:0]   seq_q, seq_d;

    logic         frame_start;
    logic         trig_rise;
    logic [6:0]   bit_base;

    assign frame_start = clken && (vc == CAPLINE) && (hc == 11'd0);
    assign trig_rise   = clken && trig && !trig_q;
    assign bit_base    = {idx_q, 3'b000};

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d  = state_q;
        dec_d    = dec_q;
        trig_d   = trig_q;
        page_d   = page_q;
        idx_d    = idx_q;
        shot_d   = shot_q;
        shadow_d = shadow_q;
        seq_d    = seq_q;
        cap_done = 1'b0;

        if (clken) begin
            trig_d = trig;
            unique case (state_q)
                S_IDLE: begin
                    if (mode == MODE_SHOT) begin
                        state_d = S_ARMED;
                    end else if (mode == MODE_RUN && frame_start) begin
                        if (dec_q == 8'd0) begin
                            state_d = S_COPY;
                            dec_d   = RELOAD;
                            shot_d  = 1'b0;
                            page_d  = page;
                            idx_d   = 4'd0;
                        end else begin
                            dec_d = dec_q - 8'd1;
                        end
                    end
                end
                // HOLD differs from ARMED only in that a held-high trig cannot fire,
                // which the edge detector already guarantees.
                S_ARMED, S_HOLD: begin
                    if (mode != MODE_SHOT) begin
                        state_d = S_IDLE;
                    end else if (trig_rise) begin
                        state_d = S_COPY;
                        shot_d  = 1'b1;
                        page_d  = page;
                        idx_d   = 4'd0;
                    end
                end
                S_COPY: begin
                    shadow_d[bit_base +: 8] = page_q ? probe_p1[bit_base +: 8]
                                                     : probe_p0[bit_base +: 8];
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        cap_done = 1'b1;
                        seq_d    = seq_q + 8'd1;
                        state_d  = shot_q ? S_HOLD : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the shadow bank is
    // plain flops and must clear on reset, so it is reset with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dec_q    <= 8'd0;
            trig_q   <= 1'b0;
            page_q   <= 1'b0;
            idx_q    <= 4'd0;
            shot_q   <= 1'b0;
            shadow_q <= '0;
            seq_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            dec_q    <= dec_d;
            trig_q   <= trig_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            shot_q   <= shot_d;
            shadow_q <= shadow_d;
            seq_q    <= seq_d;
        end
    end

    assign shadow  = shadow_q;
    assign busy    = (state_q == S_COPY);
    assign armed   = (state_q == S_ARMED);
    assign cap_seq = seq_q;

endmodule

// File: tb/tb_debug_snapshot_ctrl.sv
// Directed bench for debug_snapshot_ctrl: run/decimate, freeze, single-shot re-arm,
// mid-copy page changes, async reset mid-copy and a throttled clock enable.
module tb_debug_snapshot_ctrl;

    localparam logic [10:0] CAP = 11'd256;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clken = 1'b0;
    logic [10:0]  hc = 11'd5;
    logic [10:0]  vc = 11'd0;
    logic [1:0]   mode = 2'b00;
    logic         page = 1'b0;
    logic         trig = 1'b0;
    logic [127:0] probe_p0 = '0;
    logic [127:0] probe_p1 = '0;
    logic [127:0] shadow;
    logic         busy, armed, cap_done;
    logic [7:0]   cap_seq;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_en, done_n, clk_n;

    debug_snapshot_ctrl #(.CAPLINE(CAP), .DECIM(8'd3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clken    (clken),
        .hc       (hc),
        .vc       (vc),
        .mode     (mode),
        .page     (page),
        .trig     (trig),
        .probe_p0 (probe_p0),
        .probe_p1 (probe_p1),
        .shadow   (shadow),
        .busy     (busy),
        .armed    (armed),
        .cap_done (cap_done),
        .cap_seq  (cap_seq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [127:0] mk(input logic [7:0] base);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = base + 8'(k);
        return r;
    endfunction

    // One clk cycle; samples busy/cap_done just before the edge they refer to.
    task automatic step(input logic en);
        clken = en;
        #1;
        if (busy && en) busy_en++;
        if (cap_done) done_n++;
        @(posedge clk);
        #1;
        clk_n++;
    endtask

    task automatic clr_cnt();
        busy_en = 0;
        done_n  = 0;
        clk_n   = 0;
    endtask

    task automatic frame();
        vc = CAP;
        hc = 11'd0;
        step(1'b1);
        vc = 11'd0;
        hc = 11'd5;
    endtask

    task automatic run_copy(input int max_clk, input int duty);
        clr_cnt();
        while (busy && clk_n < max_clk) step((clk_n % duty) == duty - 1);
    endtask

    logic [127:0] exp_v;
    logic [7:0]   mask;

    initial begin
        // Reset state
        step(1'b1);
        step(1'b1);
        check("rst_shadow", shadow, '0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_armed", 128'(armed), 128'd0);
        check("rst_done", 128'(cap_done), 128'd0);
        check("rst_seq", 128'(cap_seq), 128'd0);
        rst_n = 1'b1;
        step(1'b1);

        // 1: run mode, first frame copies page 0
        probe_p0 = mk(8'h00);
        probe_p1 = mk(8'hA0);
        frame();
        check("t1_busy_start", 128'(busy), 128'd1);
        run_copy(100, 1);
        check("t1_shadow", shadow, 128'h0F0E0D0C0B0A09080706050403020100);
        check("t1_seq", 128'(cap_seq), 128'd1);
        check("t1_done_cnt", 128'(done_n), 128'd1);
        check("t1_busy_cnt", 128'(busy_en), 128'd16);
        check("t1_clk_cnt", 128'(clk_n), 128'd16);

        // 2: DECIM=3 over frames 2..7 with a frozen frame after frame 2
        mask = 8'h00;
        for (int f = 2; f <= 7; f++) begin
            probe_p0 = mk(8'(f * 16));
            frame();
            if (busy) begin
                mask[f] = 1'b1;
                run_copy(100, 1);
            end
            if (f == 2) begin
                mode = 2'b01;
                frame();
                check("t2_freeze_busy", 128'(busy), 128'd0);
                mode = 2'b00;
            end
        end
        check("t2_copy_frames", 128'(mask), 128'h90);
        check("t2_seq", 128'(cap_seq), 128'd3);
        check("t2_shadow", shadow, mk(8'h70));

        // 3: single-shot, held trig does not retrigger, re-arm on a fresh edge
        mode = 2'b10;
        step(1'b1);
        check("t3_armed", 128'(armed), 128'd1);
        probe_p0 = mk(8'h30);
        trig = 1'b1;
        step(1'b1);
        check("t3_armed_drop", 128'(armed), 128'd0);
        run_copy(100, 1);
        check("t3_busy_cnt", 128'(busy_en), 128'd16);
        check("t3_shadow1", shadow, mk(8'h30));
        check("t3_seq1", 128'(cap_seq), 128'd4);
        probe_p0 = mk(8'h40);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        check("t3_held_busy", 128'(busy), 128'd0);
        check("t3_hold_armed", 128'(armed), 128'd0);
        check("t3_held_seq", 128'(cap_seq), 128'd4);
        trig = 1'b0;
        step(1'b1);
        trig = 1'b1;
        step(1'b1);
        check("t3_rearm_busy", 128'(busy), 128'd1);
        run_copy(100, 1);
        check("t3_shadow2", shadow, mk(8'h40));
        check("t3_seq2", 128'(cap_seq), 128'd5);

        // Mode change beats a simultaneous trigger edge in ARMED
        mode = 2'b00;
        trig = 1'b0;
        step(1'b1);
        mode = 2'b10;
        step(1'b1);
        check("t3b_armed", 128'(armed), 128'd1);
        mode = 2'b00;
        trig = 1'b1;
        step(1'b1);
        check("t3b_busy", 128'(busy), 128'd0);
        check("t3b_armed_off", 128'(armed), 128'd0);

        // 4: page and probes change mid-copy; latched page, live bytes
        mode = 2'b10;
        trig = 1'b0;
        step(1'b1);
        page = 1'b1;
        probe_p0 = mk(8'h50);
        probe_p1 = mk(8'hA0);
        trig = 1'b1;
        step(1'b1);
        clr_cnt();
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                page = 1'b0;
                probe_p1 = mk(8'hC0);
                probe_p0 = mk(8'hD0);
            end
            step(1'b1);
        end
        for (int k = 0; k < 16; k++) exp_v[8*k +: 8] = (k < 8) ? 8'(8'hA0 + k) : 8'(8'hC0 + k);
        check("t4_shadow", shadow, exp_v);
        check("t4_busy_cnt", 128'(busy_en), 128'd16);
        check("t4_busy_end", 128'(busy), 128'd0);
        check("t4_seq", 128'(cap_seq), 128'd6);

        // 5: async reset at idx 7
        mode = 2'b00;
        trig = 1'b0;
        step(1'b1);
        mode = 2'b10;
        step(1'b1);
        probe_p0 = mk(8'h60);
        trig = 1'b1;
        step(1'b1);
        for (int i = 0; i < 7; i++) step(1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_shadow", shadow, '0);
        check("t5_rst_busy", 128'(busy), 128'd0);
        check("t5_rst_seq", 128'(cap_seq), 128'd0);
        check("t5_rst_done", 128'(cap_done), 128'd0);
        #2;
        rst_n = 1'b1;
        mode = 2'b00;
        trig = 1'b0;
        step(1'b1);
        frame();
        check("t5_post_busy", 128'(busy), 128'd1);
        run_copy(100, 1);
        check("t5_post_shadow", shadow, mk(8'h60));
        check("t5_post_seq", 128'(cap_seq), 128'd1);

        // 6: freeze at frame_start, then a copy under a 1/4 clock enable
        mode = 2'b01;
        probe_p0 = mk(8'hE0);
        frame();
        check("t6_freeze_busy", 128'(busy), 128'd0);
        check("t6_freeze_shadow", shadow, mk(8'h60));
        mode = 2'b00;
        frame();
        frame();
        check("t6_skip_busy", 128'(busy), 128'd0);
        probe_p0 = mk(8'h90);
        frame();
        check("t6_busy_start", 128'(busy), 128'd1);
        run_copy(200, 4);
        check("t6_clk_cnt", 128'(clk_n), 128'd64);
        check("t6_busy_cnt", 128'(busy_en), 128'd16);
        check("t6_done_cnt", 128'(done_n), 128'd1);
        check("t6_shadow", shadow, mk(8'h90));
        check("t6_seq", 128'(cap_seq), 128'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
